seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//  Multi-cycle, parametrised ripple adder built from the team's FA cell. It adds
//  two WIDTH-bit operands CHUNK bits per clock, holding the carry in a register
//  between chunks, and uses a valid/ready handshake on both input and output.
//  It is the accumulation/final-add stage of the approximate multiplier datapath.
//  An optional approximate-LSB mode trades accuracy for a shorter carry chain.
// PARAMETERS
//  WIDTH     16  operand/sum width in bits; must be a multiple of CHUNK
//  CHUNK      4  bits added per cycle; NCH = WIDTH/CHUNK chunk cycles
//  APX_BITS   4  approximate low bits, 0..WIDTH; ignored unless APPROX_LSB_EN is defined
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  registered sum
//  cout       out  1      registered carry out
//  busy       out  1      high in BUSY or DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0,
//    cout=0, chunk index=0, carry reg=0. A reset mid-operation discards all partial results.
//  - FSM: IDLE -> BUSY on in_valid&in_ready (latch a, b, cin; idx=0; carry=cin).
//    BUSY: each edge adds a[idx*CHUNK+:CHUNK] + b[same] + carry, writes the result
//    into sum[same], updates carry, and increments idx. When idx==NCH-1 the FSM moves
//    to DONE and cout = the final carry.
//    DONE: out_valid=1; sum and cout are held stable. On out_valid&out_ready -> IDLE.
//  - Latency: out_valid rises NCH edges after the accept edge. Back-to-back
//    throughput is one result per NCH+2 cycles.
//  - in_ready=0 in BUSY and DONE. in_valid in those states is ignored; a/b are not sampled.
//  - out_ready in IDLE or BUSY is ignored. out_valid never drops without a handshake.
//  - sum bits not yet processed in BUSY read 0. sum is cleared at accept.
//  - Arithmetic is modulo 2^WIDTH; the overflow bit goes to cout only.
// CONFIGURATION
//  - APPROX_LSB_EN undefined: exact addition; APX_BITS is unused.
//  - APPROX_LSB_EN defined, for bits i < APX_BITS:
//    - sum[i] = a[i]|b[i]; cin is ignored.
//    - carry out of bit i is 0, except bit APX_BITS-1, whose carry is a[i]&b[i].
//    - Bits >= APX_BITS are exact. The rule is per-bit, so a chunk may straddle the boundary.
//    - APX_BITS=0 gives exact behaviour. APX_BITS=WIDTH gives cout = a[W-1]&b[W-1].
//    - Latency and handshake are identical to exact mode.
// TESTING (WIDTH=16, CHUNK=4, APX_BITS=4)
//  1 Exact: a=0x1234 b=0x4321 cin=0 -> sum=0x5555 cout=0; out_valid rises 4 edges after accept.
//  2 Carry ripple: a=0xFFFF b=0x0000 cin=1 -> exact sum=0x0000 cout=1;
//    with APPROX_LSB_EN sum=0xFFFF cout=0.
//  3 Approx boundary (APPROX_LSB_EN): a=0x0008 b=0x0008 -> sum=0x0018 (exact 0x0010);
//    a=0x000F b=0x0001 -> sum=0x000F.
//  4 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, sum/cout
//    stable, in_ready=0. A new in_valid during the stall is not accepted.
//  5 Reset mid-op: drop rst_n during chunk 2 -> out_valid=0, sum=0, in_ready=1
//    immediately. The next op a=0x0001 b=0x0001 gives sum=0x0002.
//  6 Streaming: in_valid and out_ready held high with random operands -> one result
//    every 6 cycles, matching the reference model; random mode over 10k vectors.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder that processes CHUNK bits per clock.
// The carry is held in a register between chunks. Operands come in and results go out
// through valid/ready handshakes.
// Optional feature macro: APPROX_LSB_EN. When it is defined, the lowest APX_BITS bits
// use an OR-based approximate add with no carry chain. When it is undefined, the
// addition is exact and APX_BITS has no effect.
// WIDTH must be a multiple of CHUNK.

// Single-bit full adder cell used to build each chunk.
module seq_chunk_adder_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module seq_chunk_adder #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter int APX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef APPROX_LSB_EN
  localparam bit APX_ON = 1'b1;
`else
  localparam bit APX_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic              r_cout;
  logic [IDXW-1:0]   r_idx;

  logic              w_accept;
  logic              w_last;
  logic [CHUNK-1:0]  w_ca;
  logic [CHUNK-1:0]  w_cb;
  logic [CHUNK-1:0]  w_cs;
  logic [CHUNK:0]    w_c;

  // Select the operand chunk for the current index. The carry register seeds the chain.
  assign w_ca     = r_a[r_idx*CHUNK +: CHUNK];
  assign w_cb     = r_b[r_idx*CHUNK +: CHUNK];
  assign w_c[0]   = r_carry;
  assign w_last   = (r_idx == IDXW'(NCH - 1));
  assign w_accept = in_valid & in_ready;

  // Chunk adder. Bits below the approximate boundary are chosen per bit (the global
  // bit position is used), so a chunk may straddle that boundary.
  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_bit
      logic [31:0] w_pos;
      logic        w_fs;
      logic        w_fc;
      logic        w_apx;
      logic        w_apx_top;

      assign w_pos = 32'(r_idx) * 32'(CHUNK) + 32'(gi);

      seq_chunk_adder_fa u_fa (
        .i_a (w_ca[gi]),
        .i_b (w_cb[gi]),
        .i_c (w_c[gi]),
        .o_s (w_fs),
        .o_c (w_fc)
      );

      // Approximate bits ignore the incoming carry. Only the top approximate bit
      // generates a carry into the exact region.
      assign w_apx     = APX_ON && (w_pos < 32'(APX_BITS));
      assign w_apx_top = (w_pos == (32'(APX_BITS) - 32'd1));
      assign w_cs[gi]  = w_apx ? (w_ca[gi] | w_cb[gi]) : w_fs;
      assign w_c[gi+1] = w_apx ? (w_apx_top & w_ca[gi] & w_cb[gi]) : w_fc;
    end
  endgenerate

  // State register. An asynchronous reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs. All outputs are decoded from the state alone.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands and clear the result at accept, then write one chunk per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= cin;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == S_BUSY) begin
      r_sum[r_idx*CHUNK +: CHUNK] <= w_cs;
      r_carry                     <= w_c[CHUNK];
      r_idx                       <= r_idx + IDXW'(1);
      if (w_last) r_cout <= w_c[CHUNK];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder (WIDTH=16, CHUNK=4, APX_BITS=4).
// The expected values follow the APPROX_LSB_EN macro in the same way as the design.
module tb_seq_chunk_adder;

  localparam int W   = 16;
  localparam int APX = 4;
  localparam int NV  = 10000;

`ifdef APPROX_LSB_EN
  localparam logic [15:0] E_RIP_S = 16'hFFFF;  localparam logic E_RIP_C = 1'b0;
  localparam logic [15:0] E_B1_S  = 16'h0018;
  localparam logic [15:0] E_B2_S  = 16'h000F;
  localparam logic [15:0] E_MSB_S = 16'h0000;
  localparam logic [15:0] E_BP_S  = 16'hBCDD;
  localparam logic [15:0] E_ONE_S = 16'h0001;
`else
  localparam logic [15:0] E_RIP_S = 16'h0000;  localparam logic E_RIP_C = 1'b1;
  localparam logic [15:0] E_B1_S  = 16'h0010;
  localparam logic [15:0] E_B2_S  = 16'h0010;
  localparam logic [15:0] E_MSB_S = 16'h0001;
  localparam logic [15:0] E_BP_S  = 16'hBCDE;
  localparam logic [15:0] E_ONE_S = 16'h0002;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(4), .APX_BITS(APX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: {cout, sum}
  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [12:0] hi;
`ifdef APPROX_LSB_EN
    hi = {1'b0, x[15:4]} + {1'b0, y[15:4]} + 13'(x[3] & y[3]);
    return {hi, x[3:0] | y[3:0]};
`else
    hi = '0;
    return ({1'b0, x} + {1'b0, y} + 17'(c)) | 17'(hi);
`endif
  endfunction

  // Present operands at a negedge. Return #1 after the accept edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count the edges from accept until out_valid is seen. The wait is bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic [15:0] es, input logic ec);
    int lat;
    start_op(ta, tb_v, tc);
    check({tag, ".clr"}, sum, 32'h0);
    check({tag, ".busy"}, busy, 32'h1);
    wait_valid(lat);
    check({tag, ".lat"}, lat, 32'd4);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".rdy"}, in_ready, 32'h0);
    $display("%s a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d", tag, ta, tb_v, tc, sum, cout, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".ovl"}, out_valid, 32'h0);
    check({tag, ".irdy"}, in_ready, 32'h1);
  endtask

  initial begin
    int lat;
    logic [16:0] e;
    logic [15:0] held;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 32'h1);
    check("rst.out_valid", out_valid, 32'h0);
    check("rst.busy", busy, 32'h0);
    check("rst.sum", sum, 32'h0);
    check("rst.cout", cout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op("exact", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0000, 1'b1, E_RIP_S, E_RIP_C);
    do_op("bound1", 16'h0008, 16'h0008, 1'b0, E_B1_S, 1'b0);
    do_op("bound2", 16'h000F, 16'h0001, 1'b0, E_B2_S, 1'b0);
    do_op("msb", 16'h8000, 16'h8000, 1'b1, E_MSB_S, 1'b1);

    // Backpressure: the result stalls in DONE while a new request is ignored.
    start_op(16'hABCD, 16'h1111, 1'b0);
    wait_valid(lat);
    check("bp.lat", lat, 32'd4);
    check("bp.sum", sum, E_BP_S);
    held = sum;
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.ovl", out_valid, 32'h1);
      check("bp.hold", sum, held);
      check("bp.cout", cout, 32'h0);
      check("bp.in_ready", in_ready, 32'h0);
    end
    $display("backpressure a=abcd b=1111 sum=%h held 5 cycles", sum);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp.idle", busy, 32'h0);
    check("bp.sum_kept", sum, E_BP_S);

    // Reset during chunk 2 discards the partial result.
    start_op(16'h1234, 16'h1111, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", out_valid, 32'h0);
    check("mrst.sum", sum, 32'h0);
    check("mrst.in_ready", in_ready, 32'h1);
    check("mrst.busy", busy, 32'h0);
    $display("midop reset sum=%h in_ready=%b", sum, in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, E_ONE_S, 1'b0);

    // Streaming with in_valid and out_ready both held high
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < NV; k++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      e   = ref_add(a, b, cin);
      @(posedge clk); #1;           // accept
      wait_valid(lat);
      check("stream", {lat[7:0], 7'd0, cout, sum}, {8'd4, 7'd0, e});
      $display("stream %0d a=%h b=%h cin=%b sum=%h cout=%b", k, a, b, cin, sum, cout);
      @(posedge clk); #1;           // handshake
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
